// File: rtl/pbuf_pkg.sv
// Shared definitions for the programmable buffer bank: mode encodings and chain sizing.
package pbuf_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_PASS = 2'b01;
    localparam logic [MODE_W-1:0] MODE_INV  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_REG  = 2'b11;

    function automatic int chain_len(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/pbuf_chan.sv
// One buffer channel: selects pass/invert/registered data and floats the output when off.
module pbuf_chan
    import pbuf_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    input  logic              in,
    input  logic              reg_q,
    output logic              out
);

    logic data;

    always_comb begin
        data = 1'b0;
        case (mode)
            MODE_PASS: data = in;
            MODE_INV:  data = ~in;
            MODE_REG:  data = reg_q;
            default:   data = 1'b0;
        endcase
    end

    assign out = (mode != MODE_OFF) ? data : 1'bz;

endmodule

// File: rtl/pbuf_bank.sv
// N_CH-channel programmable tristate buffer with a shadowed serial config chain and
// a bit-count-validated commit into the active configuration.
module pbuf_bank
    import pbuf_pkg::*;
#(
    parameter int                N_CH       = 6,
    parameter logic [MODE_W-1:0] RESET_MODE = MODE_OFF
) (
    input  logic            prog_clk,
    input  logic            prog_rst_n,
    input  logic            prog_en,
    input  logic            prog_in,
    input  logic            prog_commit,
    output logic            prog_out,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] out,
    output logic            cfg_ok,
    output logic            cfg_err
);

    localparam int CHAIN_LEN = chain_len(N_CH);
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] sh_q, sh_d;
    logic [CHAIN_LEN-1:0] act_q, act_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 cfg_ok_q, cfg_ok_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [N_CH-1:0]      reg_q, reg_d;

    // Commit has priority over shifting and always sees the pre-edge chain and count.
    always_comb begin
        sh_d      = sh_q;
        act_d     = act_q;
        count_d   = count_q;
        cfg_ok_d  = cfg_ok_q;
        cfg_err_d = cfg_err_q;
        reg_d     = in;
        if (prog_commit) begin
            count_d = '0;
            if (count_q == CNT_FULL) begin
                act_d     = sh_q;
                cfg_ok_d  = 1'b1;
                cfg_err_d = 1'b0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (prog_en) begin
            sh_d = {sh_q[CHAIN_LEN-2:0], prog_in};
            if (count_q != CNT_SAT) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            sh_q      <= '0;
            act_q     <= {N_CH{RESET_MODE}};
            count_q   <= '0;
            cfg_ok_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            reg_q     <= '0;
        end else begin
            sh_q      <= sh_d;
            act_q     <= act_d;
            count_q   <= count_d;
            cfg_ok_q  <= cfg_ok_d;
            cfg_err_q <= cfg_err_d;
            reg_q     <= reg_d;
        end
    end

    assign prog_out = sh_q[CHAIN_LEN-1];
    assign cfg_ok   = cfg_ok_q;
    assign cfg_err  = cfg_err_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        pbuf_chan u_chan (
            .mode  (act_q[gi*MODE_W +: MODE_W]),
            .in    (in[gi]),
            .reg_q (reg_q[gi]),
            .out   (out[gi])
        );
    end

endmodule
